// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry skid buffer for downstream stalls.
// Optional PC redirect support (with DROP state) is enabled by defining INST_FETCH_REDIRECT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
`ifdef INST_FETCH_REDIRECT_EN
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`endif
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef INST_FETCH_REDIRECT_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
`ifdef INST_FETCH_REDIRECT_EN
    logic [31:0] pending_pc;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ~32'h0000_0003;
`endif

    // The address bus always shows pc; in DROP pc still holds the abandoned address.
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            if_inst   <= NOP;
            if_pc     <= 32'h0000_0000;
            if_valid  <= 1'b0;
            skid_inst <= 32'h0000_0000;
            skid_pc   <= 32'h0000_0000;
`ifdef INST_FETCH_REDIRECT_EN
            pending_pc <= 32'h0000_0000;
`endif
        end else begin
`ifdef INST_FETCH_REDIRECT_EN
            if (redirect_valid) begin
                if_valid <= 1'b0;
                if_inst  <= NOP;
                imem_req <= 1'b1;
                // An unanswered request cannot be cancelled, so park the target until it returns.
                if ((state == REQ || state == DROP) && !imem_ack) begin
                    pending_pc <= redirect_target;
                    state      <= DROP;
                end else begin
                    pc    <= redirect_target;
                    state <= REQ;
                end
            end else
`endif
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= pc;
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                        end else begin
                            if_inst  <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_inst  <= NOP;
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_inst  <= skid_inst;
                        if_pc    <= skid_pc;
                        if_valid <= 1'b1;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
`ifdef INST_FETCH_REDIRECT_EN
                DROP: begin
                    if (imem_ack) begin
                        pc    <= pending_pc;
                        state <= REQ;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random ack/stall traffic checked against a queue-based model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFE8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
`ifdef INST_FETCH_REDIRECT_EN
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
`ifdef INST_FETCH_REDIRECT_EN
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
`endif
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_valid      (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: the next address to fetch, a queue of fetched-but-undelivered words,
    // and what the decoder should currently see.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    bit          m_started;
    logic [31:0] m_next;
    word_t       m_buf[$];
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_valid;
`ifdef INST_FETCH_REDIRECT_EN
    bit          m_drop;
    logic [31:0] m_pending;
`endif

    function automatic bit m_requesting();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_next    = RESET_PC;
        m_buf.delete();
        m_inst    = NOP;
        m_pc      = 32'h0;
        m_valid   = 1'b0;
`ifdef INST_FETCH_REDIRECT_EN
        m_drop    = 0;
        m_pending = 32'h0;
`endif
    endtask

    task automatic model_step(input logic ack, input logic stl, input logic [31:0] rdata);
        word_t w;
`ifdef INST_FETCH_REDIRECT_EN
        if (redirect_valid) begin
            m_valid = 1'b0;
            m_inst  = NOP;
            if (m_requesting() && !ack) begin
                m_drop    = 1;
                m_pending = redirect_pc;
            end else begin
                m_buf.delete();
                m_next    = redirect_pc;
                m_drop    = 0;
                m_started = 1;
            end
            return;
        end
        if (m_drop) begin
            if (ack) begin
                m_next = m_pending;
                m_drop = 0;
            end
            return;
        end
`endif
        if (!m_started) begin
            m_started = 1;
        end else if (m_buf.size() != 0) begin
            if (!stl) begin
                w       = m_buf.pop_front();
                m_inst  = w.inst;
                m_pc    = w.pc;
                m_valid = 1'b1;
            end
        end else if (ack) begin
            w.pc   = m_next;
            w.inst = rdata;
            m_next = m_next + 32'd4;
            if (stl) begin
                m_buf.push_back(w);
            end else begin
                m_inst  = w.inst;
                m_pc    = w.pc;
                m_valid = 1'b1;
            end
        end else if (!stl) begin
            m_inst  = NOP;
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_output();
        check("imem_req", {31'd0, imem_req}, {31'd0, m_requesting()});
        check("imem_addr", imem_addr, m_next);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("if_inst", if_inst, m_inst);
        check("if_pc", if_pc, m_pc);
    endtask

    task automatic check_reset_values();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_inst", if_inst, NOP);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, re-check at the next fall.
    task automatic apply_stimulus(input logic ack, input logic stl, input logic [31:0] rdata);
        imem_ack   = ack;
        stall      = stl;
        imem_rdata = rdata;
        @(posedge clk);
        model_step(ack, stl, rdata);
        @(negedge clk);
        check_output();
    endtask

    task automatic reach_addr(input logic [31:0] addr, input int budget);
        int n = 0;
        while (!(m_requesting() && m_next == addr) && n < budget) begin
            apply_stimulus(1'b1, 1'b0, $urandom);
            n++;
        end
        if (!(m_requesting() && m_next == addr)) begin
            checks++;
            errors++;
            $error("[TB] FAIL reach_addr: observed %h expected %h", m_next, addr);
        end
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
`ifdef INST_FETCH_REDIRECT_EN
            redirect_valid = ($urandom_range(99) < 5);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
`endif
            apply_stimulus($urandom_range(99) < 70, $urandom_range(99) < 30, $urandom);
        end
`ifdef INST_FETCH_REDIRECT_EN
        redirect_valid = 1'b0;
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        stall      = 1'b0;
        imem_rdata = 32'h0;
`ifdef INST_FETCH_REDIRECT_EN
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        check_output();
        rst_n = 1'b1;

        $display("[TB] sequential fetch with ack tied high, crossing the address wrap");
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, $urandom);

        $display("[TB] stall while the word at 0x8 returns");
        reach_addr(32'h8, 20);
        apply_stimulus(1'b1, 1'b1, 32'h00A0_0093);
        apply_stimulus(1'b1, 1'b1, $urandom);
        check("hold_imem_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus(1'b1, 1'b0, $urandom);
        check("skid_inst", if_inst, 32'h00A0_0093);
        check("skid_pc", if_pc, 32'h8);
        check("skid_valid", {31'd0, if_valid}, 32'd1);

        $display("[TB] ack held low for three cycles at 0x10");
        reach_addr(32'h10, 20);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, $urandom);
            check("wait_addr", imem_addr, 32'h10);
            check("wait_inst", if_inst, NOP);
            check("wait_valid", {31'd0, if_valid}, 32'd0);
        end
        apply_stimulus(1'b1, 1'b0, $urandom);

`ifdef INST_FETCH_REDIRECT_EN
        $display("[TB] redirect to 0x200 while the request at 0x40 is outstanding");
        reach_addr(32'h40, 40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        apply_stimulus(1'b0, 1'b0, $urandom);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b0, $urandom);
            check("drop_addr", imem_addr, 32'h40);
        end
        apply_stimulus(1'b1, 1'b0, $urandom);
        check("redir_addr", imem_addr, 32'h200);
        check("redir_valid", {31'd0, if_valid}, 32'd0);
`endif

        $display("[TB] random ack/stall traffic");
        random_phase(400);

        $display("[TB] asynchronous reset in the middle of a request");
        for (int i = 0; i < 6 && !m_requesting(); i++) apply_stimulus(1'b0, 1'b0, $urandom);
        check("pre_reset_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;
        stall    = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        check_output();
        @(negedge clk);
        check_output();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, $urandom);
        random_phase(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
